// File: rtl/condicionador_botoes.sv
// Dual-button input conditioner.
// Each raw pin is polarity-normalised, synchronised and debounced; the
// debounced levels are then classified into short press, long press and
// two-button combo gestures, each reported as a registered one-cycle pulse.
module condicionador_botoes #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 25000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic b1_raw,
    input  logic b2_raw,
    output logic b1_level,
    output logic b2_level,
    output logic b1_press,
    output logic b2_press,
    output logic b1_long,
    output logic b2_long,
    output logic combo
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

    typedef enum logic [1:0] {
        B_IDLE,
        B_DOWN,
        B_LONG,
        B_CONSUMED
    } btn_state_t;

    // Index 0 is button 1, index 1 is button 2 throughout.
    logic [1:0]    pin_pressed;
    logic [1:0]    sync_a;
    logic [1:0]    sync_b;
    logic [1:0]    level;
    logic [1:0]    level_d;
    logic [1:0]    rise;
    logic [1:0]    fall;
    logic [DW-1:0] deb_cnt [2];
    logic [HW-1:0] hold_cnt [2];
    btn_state_t    state [2];
    btn_state_t    state_next [2];
    logic [1:0]    down;
    logic [1:0]    press_next;
    logic [1:0]    long_next;
    logic          combo_next;
    logic [1:0]    press_q;
    logic [1:0]    long_q;
    logic          combo_q;

    // From here on a 1 always means "pressed", whatever the board wiring.
    assign pin_pressed = ACTIVE_LOW ? ~{b2_raw, b1_raw} : {b2_raw, b1_raw};

    // Two-flop synchroniser; reset loads the not-pressed level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            // NOTE: non-blocking assignments make sync_b take the previous
            // sync_a, so these really are two flops in series.
            sync_a <= pin_pressed;
            sync_b <= sync_a;
        end
    end

    // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level   <= '0;
            level_d <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            level_d <= level;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] != level[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        level[i]   <= ~level[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Level edges, seen in the cycle after the debounced level changes.
    assign rise = level & ~level_d;
    assign fall = ~level & level_d;

    // Hold timer: held at zero while released, so every press starts from zero;
    // counts pressed cycles and saturates at LONG_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!level[i]) begin
                    hold_cnt[i] <= '0;
                end else if (hold_cnt[i] != HOLD_MAX) begin
                    hold_cnt[i] <= hold_cnt[i] + HW'(1);
                end
            end
        end
    end

    // Button FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= B_IDLE;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= state_next[i];
            end
        end
    end

    // Gesture decode: combo wins over any pending press/long of a button in B_DOWN.
    always_comb begin
        // NOTE: every signal gets a default before any condition, so no path
        // through this block can leave a latch behind.
        down       = '0;
        press_next = '0;
        long_next  = '0;
        for (int i = 0; i < 2; i++) begin
            down[i] = (state[i] == B_DOWN);
        end
        combo_next = (rise[0] && (down[1] || rise[1])) || (rise[1] && down[0]);
        for (int i = 0; i < 2; i++) begin
            long_next[i]  = down[i] && !combo_next && (hold_cnt[i] == HOLD_MAX);
            press_next[i] = down[i] && !combo_next && fall[i] && (hold_cnt[i] != HOLD_MAX);
        end
    end

    // Next-state logic; B_LONG and B_CONSUMED wait silently for their own release.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_next[i] = state[i];
            case (state[i])
                B_IDLE: begin
                    if (rise[i]) begin
                        state_next[i] = combo_next ? B_CONSUMED : B_DOWN;
                    end
                end
                B_DOWN: begin
                    if (combo_next) begin
                        state_next[i] = B_CONSUMED;
                    end else if (long_next[i]) begin
                        state_next[i] = B_LONG;
                    end else if (press_next[i]) begin
                        state_next[i] = B_IDLE;
                    end
                end
                B_LONG, B_CONSUMED: begin
                    if (!level[i]) begin
                        state_next[i] = B_IDLE;
                    end
                end
                default: state_next[i] = B_IDLE;
            endcase
        end
    end

    // Registered one-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_q <= '0;
            long_q  <= '0;
            combo_q <= 1'b0;
        end else begin
            press_q <= press_next;
            long_q  <= long_next;
            combo_q <= combo_next;
        end
    end

    assign b1_level = level[0];
    assign b2_level = level[1];
    assign b1_press = press_q[0];
    assign b2_press = press_q[1];
    assign b1_long  = long_q[0];
    assign b2_long  = long_q[1];
    assign combo    = combo_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes: directed gestures with literal expectations
// plus randomised pin activity, all checked every cycle against a timestamp
// based gesture model.
module tb_condicionador_botoes;

    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic clk = 1'b0;
    logic rst;
    logic b1_raw;
    logic b2_raw;
    logic b1_level, b2_level, b1_press, b2_press, b1_long, b2_long, combo;

    always #5 clk = ~clk;

    condicionador_botoes #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .b1_raw  (b1_raw),
        .b2_raw  (b2_raw),
        .b1_level(b1_level),
        .b2_level(b2_level),
        .b1_press(b1_press),
        .b2_press(b2_press),
        .b1_long (b1_long),
        .b2_long (b2_long),
        .combo   (combo)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Levels: a pin value two edges old must disagree with the level for DEB
    // consecutive edges before the level flips. Gestures: each press records
    // the edge its level rose; an open (unresolved) press becomes a combo,
    // a long press or a short press purely from those timestamps.
    int cyc_n;
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_lv [2];
    int m_run [2];
    int rise_e [2];
    int fall_e [2];
    bit pend [2];
    bit e_press [2];
    bit e_long [2];
    bit e_combo;

    task automatic model_step();
        bit nw;
        if (rst) begin
            cyc_n   = 0;
            e_combo = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lv[i] = 0; m_run[i] = 0;
                rise_e[i] = -100; fall_e[i] = -100; pend[i] = 0;
                e_press[i] = 0; e_long[i] = 0;
            end
        end else begin
            cyc_n++;
            e_combo = 1'b0;
            for (int i = 0; i < 2; i++) begin
                e_press[i] = 0;
                e_long[i]  = 0;
            end
            if (pend[0] && pend[1] && (rise_e[0] == cyc_n - 1 || rise_e[1] == cyc_n - 1)) begin
                e_combo = 1'b1;
                pend[0] = 0;
                pend[1] = 0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (pend[i]) begin
                        if (cyc_n == rise_e[i] + LONG + 1) begin
                            e_long[i] = 1; pend[i] = 0;
                        end else if (fall_e[i] == cyc_n - 1) begin
                            e_press[i] = 1; pend[i] = 0;
                        end
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                nw = (i == 0) ? !b1_raw : !b2_raw;
                if (m_s2[i] != m_lv[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == DEB) begin
                    m_run[i] = 0;
                    m_lv[i]  = !m_lv[i];
                    if (m_lv[i]) begin
                        rise_e[i] = cyc_n;
                        pend[i]   = 1;
                    end else begin
                        fall_e[i] = cyc_n;
                    end
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = nw;
            end
        end
    endtask

    always @(posedge clk or posedge rst) model_step();

    // ---------------- per-cycle compare and pulse counting ----------------
    int dcnt [5] = '{0, 0, 0, 0, 0};
    int mcnt [5] = '{0, 0, 0, 0, 0};
    int snap_d [5];
    int snap_m [5];

    always @(negedge clk) begin
        if (chk_en) begin
            check("b1_level", int'(b1_level), int'(m_lv[0]));
            check("b2_level", int'(b2_level), int'(m_lv[1]));
            check("b1_press", int'(b1_press), int'(e_press[0]));
            check("b2_press", int'(b2_press), int'(e_press[1]));
            check("b1_long",  int'(b1_long),  int'(e_long[0]));
            check("b2_long",  int'(b2_long),  int'(e_long[1]));
            check("combo",    int'(combo),    int'(e_combo));
            if (b1_press) dcnt[0]++;
            if (b2_press) dcnt[1]++;
            if (b1_long)  dcnt[2]++;
            if (b2_long)  dcnt[3]++;
            if (combo)    dcnt[4]++;
            if (e_press[0]) mcnt[0]++;
            if (e_press[1]) mcnt[1]++;
            if (e_long[0])  mcnt[2]++;
            if (e_long[1])  mcnt[3]++;
            if (e_combo)    mcnt[4]++;
        end
    end

    // ---------------- helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic int outs();
        return int'({b1_level, b2_level, b1_press, b2_press, b1_long, b2_long, combo});
    endfunction

    function automatic bit sig(input int sel);
        case (sel)
            0:       return b1_level;
            1:       return b2_level;
            default: return b1_long;
        endcase
    endfunction

    // Edges until the selected output reads 1; -1 if it never does within 60.
    task automatic wait_sig(input int sel, output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #2;
            if (sig(sel)) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 5; i++) begin
            snap_d[i] = dcnt[i];
            snap_m[i] = mcnt[i];
        end
    endtask

    task automatic check_counts(input string tag, input int p1, input int p2,
                                input int l1, input int l2, input int c);
        string nm [5] = '{"b1_press", "b2_press", "b1_long", "b2_long", "combo"};
        int    ex [5];
        ex = '{p1, p2, l1, l2, c};
        for (int i = 0; i < 5; i++) begin
            check({tag, "_dut_", nm[i]}, dcnt[i] - snap_d[i], ex[i]);
            check({tag, "_model_", nm[i]}, mcnt[i] - snap_m[i], ex[i]);
        end
    endtask

    function automatic int pick_dwell();
        if ($urandom_range(0, 2) == 0) return int'($urandom_range(1, 5));
        return int'($urandom_range(6, 45));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int rem [2];

        rst    = 1'b1;
        b1_raw = 1'b1;
        b2_raw = 1'b1;
        cyc(2);
        chk_en = 1'b1;
        check("reset_outs", outs(), 0);
        cyc(1);
        rst = 1'b0;
        cyc(4);

        // 1: short press of button 1
        snap();
        b1_raw = 1'b0;
        wait_sig(0, lat);
        check("t1_rise_latency", lat, 6);
        cyc(4);
        b1_raw = 1'b1;
        cyc(12);
        check_counts("t1", 1, 0, 0, 0, 0);

        // 2: glitches on button 2 shorter than the debounce window
        snap();
        for (int r = 0; r < 5; r++) begin
            b2_raw = 1'b0;
            cyc(3);
            b2_raw = 1'b1;
            cyc(3);
        end
        cyc(8);
        check("t2_b2_level", int'(b2_level), 0);
        check_counts("t2", 0, 0, 0, 0, 0);

        // 3: long press of button 1
        snap();
        b1_raw = 1'b0;
        wait_sig(0, lat);
        check("t3_rise_latency", lat, 6);
        wait_sig(2, lat);
        check("t3_long_latency", lat, 21);
        cyc(13);
        b1_raw = 1'b1;
        cyc(12);
        check_counts("t3", 0, 0, 1, 0, 0);

        // 4: combo, b2 pressed while b1 is down
        snap();
        b1_raw = 1'b0;
        wait_sig(0, lat);
        cyc(5);
        b2_raw = 1'b0;
        cyc(16);
        b1_raw = 1'b1;
        cyc(8);
        b2_raw = 1'b1;
        cyc(12);
        check_counts("t4", 0, 0, 0, 0, 1);

        // 5: b2 tapped while b1 already long-held: no combo
        snap();
        b1_raw = 1'b0;
        wait_sig(0, lat);
        cyc(25);
        b2_raw = 1'b0;
        cyc(8);
        b2_raw = 1'b1;
        cyc(12);
        b1_raw = 1'b1;
        cyc(12);
        check_counts("t5", 0, 1, 1, 0, 0);

        // 6: reset mid-debounce with button 1 still held
        snap();
        b1_raw = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        check("t6_reset_outs", outs(), 0);
        cyc(2);
        rst = 1'b0;
        wait_sig(0, lat);
        check("t6_rise_latency", lat, 6);
        cyc(5);
        b1_raw = 1'b1;
        cyc(12);
        check_counts("t6", 1, 0, 0, 0, 0);

        // Random pin activity with occasional resets, checked cycle by cycle.
        rem[0] = 5;
        rem[1] = 9;
        for (int c = 0; c < 4000; c++) begin
            if (rem[0] == 0) begin
                b1_raw = ~b1_raw;
                rem[0] = pick_dwell();
            end else begin
                rem[0]--;
            end
            if (rem[1] == 0) begin
                b2_raw = ~b2_raw;
                rem[1] = pick_dwell();
            end else begin
                rem[1]--;
            end
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
                cyc(2);
                rst = 1'b0;
            end
            cyc(1);
        end

        b1_raw = 1'b1;
        b2_raw = 1'b1;
        cyc(80);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/condicionador_botoes.md
Name: condicionador_botoes

Overview:
Dual-button input conditioner that sits between the raw board pins and the state controller. For each button it synchronises and debounces the pin, then classifies every gesture as a short press, a long press, or a two-button combo. Each class is delivered as a single-cycle pulse, so the state controller only ever sees clean events.

Parameters:
DEBOUNCE_CYCLES, 250000, cycles the synchronised input must stay at a new level before it is accepted (10 ms at 25 MHz); must be ≥2.
LONG_CYCLES, 25000000, debounced hold time that qualifies as a long press (1 s); must be > DEBOUNCE_CYCLES.
ACTIVE_LOW, 1, 1 = raw pins read 0 when pressed; 0 = pins read 1 when pressed.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
b1_raw  input  1  raw pin, button 1
b2_raw  input  1  raw pin, button 2
b1_level  output  1  debounced level of button 1, 1 = pressed
b2_level  output  1  debounced level of button 2, 1 = pressed
b1_press  output  1  one-cycle pulse: short press of button 1
b2_press  output  1  one-cycle pulse: short press of button 2
b1_long  output  1  one-cycle pulse: long press of button 1
b2_long  output  1  one-cycle pulse: long press of button 2
combo  output  1  one-cycle pulse: both buttons pressed together

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - Synchronisers load the not-pressed level.
  - Counters cleared; both button FSMs in B_IDLE.
- Input path: raw pin → polarity normalise (per ACTIVE_LOW) → 2-FF synchroniser.
- Debounce, per button:
  - Counter increments while the synchronised value differs from bX_level.
  - Counter clears on any cycle the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, bX_level toggles on the next edge and the counter clears.
  - Latency from a stable raw change to bX_level change: 2 + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES never reach bX_level.
- Hold counter, per button:
  - Cleared on the rising edge of bX_level.
  - Increments while bX_level=1; saturates at LONG_CYCLES.
- Button FSM, per button:
  - B_IDLE → B_DOWN on the rising edge of bX_level, unless that edge triggers a combo, in which case → B_CONSUMED.
  - B_DOWN, falling edge of bX_level with hold < LONG_CYCLES: bX_press=1 for 1 cycle → B_IDLE.
  - B_DOWN, hold counter reaches LONG_CYCLES: bX_long=1 for 1 cycle (issued while the button is still held) → B_LONG.
  - B_LONG, falling edge: → B_IDLE, no pulse.
  - B_CONSUMED, falling edge: → B_IDLE, no pulse.
- Combo detection:
  - Fires when a rising edge of one level occurs while the other button is in B_DOWN, or when both rising edges land in the same cycle.
  - Response: combo=1 for 1 cycle in the cycle after the edge; both FSMs go to B_CONSUMED.
  - A button in B_LONG is excluded. Pressing the other button then yields no combo; that button proceeds independently through B_DOWN.
  - Releasing one button of a combo does not release the other. Each leaves B_CONSUMED only on its own falling edge.
- Pulse timing:
  - Every pulse is registered and asserted in the cycle after its triggering level event.
  - At most one pulse type per button per gesture.
  - b1_press and b2_press may coincide in the same cycle.
- Reset mid-gesture: no pulse is emitted. If a button is still held when reset releases, it is reported as a new press after 2 + DEBOUNCE_CYCLES cycles.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1):
1. Hold b1_raw=0 for 10 cycles, then release → b1_level rises 6 cycles after the press; one b1_press pulse follows the debounced release; b1_long and combo stay 0.
2. Toggle b2_raw with 3-cycle low pulses and 3-cycle high gaps, repeated 5 times → b2_level stays 0; no pulses on any output.
3. Hold b1_raw=0 for 40 cycles → exactly one b1_long pulse, 21 cycles after b1_level rises; no b1_press on release.
4. Press b1; 5 cycles after b1_level rises, press b2; hold both for 10 cycles; release b1, then b2 → exactly one combo pulse; zero press and long pulses for either button.
5. Press b1 for 25 cycles (b1_long fires), then press and release b2 for 8 cycles while b1 is still held → combo stays 0; one b2_press pulse.
6. Assert rst while b1 is held mid-debounce, release rst with b1 still held → all outputs 0 during reset; b1_level rises 6 cycles after release; b1_press pulses on the later debounced release.
